// File: rtl/energy_tracker.sv
// Saturating energy level with a prescaled step, activity drain and a hysteretic 2-bit band.
// Optional ENERGY_TRACKER_BOOST_EN adds a boost input that forces the level to max.
module energy_tracker #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned INC_STEP = 2,
  parameter int unsigned DEC_STEP = 1,
  parameter int unsigned ACT_COST = 8,
  parameter int unsigned TH_LOW   = 64,
  parameter int unsigned TH_MID   = 128,
  parameter int unsigned TH_HIGH  = 224,
  parameter int unsigned HYST     = 4,
  parameter int unsigned INIT     = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_inc,
  input  logic             en_dec,
  input  logic             activity,
`ifdef ENERGY_TRACKER_BOOST_EN
  input  logic             boost,
`endif
  output logic [WIDTH-1:0] energy_level,
  output logic [1:0]       energy_indicator,
  output logic             exhausted,
  output logic             full,
  output logic             tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DW = WIDTH + 2;
  localparam int unsigned SW = WIDTH + 3;
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [1:0] INIT_BAND = (INIT >= TH_HIGH) ? 2'b11 :
                                     (INIT >= TH_MID)  ? 2'b10 :
                                     (INIT >= TH_LOW)  ? 2'b01 : 2'b00;

  typedef enum logic [1:0] {
    B0 = 2'b00,
    B1 = 2'b01,
    B2 = 2'b10,
    B3 = 2'b11
  } band_t;

  logic [CW-1:0]        cnt;
  logic                 step;
  logic signed [DW-1:0] delta;
  logic [SW-1:0]        sum;
  logic [WIDTH-1:0]     level_next;
  band_t                band_q;
  band_t                band_d;

  assign step = (cnt == CW'(PRESCALE - 1));

  // Prescaler: the step lands on the edge ending the PRESCALE-1 cycle, tick follows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= step ? '0 : cnt + CW'(1);
      tick <= step;
    end
  end

  // Net signed delta for this cycle, then clamp the sum into [0, MAX]
  always_comb begin
    delta = '0;
    if (step && en_inc && !en_dec) delta = delta + DW'(INC_STEP);
    if (step && en_dec && !en_inc) delta = delta - DW'(DEC_STEP);
    if (activity)                  delta = delta - DW'(ACT_COST);
    sum = {3'b000, energy_level} + {delta[DW-1], delta};
    if (sum[SW-1])
      level_next = '0;
    else if (sum > {3'b000, MAX})
      level_next = MAX;
    else
      level_next = sum[WIDTH-1:0];
`ifdef ENERGY_TRACKER_BOOST_EN
    if (boost) level_next = MAX;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy_level <= WIDTH'(INIT);
      exhausted    <= (INIT == 0);
      full         <= (INIT == (2**WIDTH - 1));
    end else begin
      energy_level <= level_next;
      exhausted    <= (level_next == '0);
      full         <= (level_next == MAX);
    end
  end

  // Band state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) band_q <= band_t'(INIT_BAND);
    else        band_q <= band_d;
  end

  // Band next-state: one band per cycle, downward moves use the hysteresis margin
  always_comb begin
    band_d = band_q;
    case (band_q)
      B0: if (energy_level >= WIDTH'(TH_LOW)) band_d = B1;
      B1: begin
        if (energy_level >= WIDTH'(TH_MID))             band_d = B2;
        else if (energy_level < WIDTH'(TH_LOW - HYST))  band_d = B0;
      end
      B2: begin
        if (energy_level >= WIDTH'(TH_HIGH))            band_d = B3;
        else if (energy_level < WIDTH'(TH_MID - HYST))  band_d = B1;
      end
      B3: if (energy_level < WIDTH'(TH_HIGH - HYST))    band_d = B2;
      default: band_d = B0;
    endcase
  end

  assign energy_indicator = band_q;

endmodule
